enemy_chaser_n: RTL and testbench

// - Parametrised enemy ship: spawns at top, descends to FOLLOW_Y, then chases the player with a dead-band.
// - Checks overlap against NUM_LASERS player lasers and the player ship every frame.
// - Applies difficulty-scaled damage, plays a fixed-length explosion, then clears itself.
// - One instance per enemy slot; sits between the spawn controller and the sprite/score logic.

---
 rtl/enemy_chaser_n.sv | 212 +++++++++++++++++++++
 tb/tb_enemy_chaser_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_chaser_n.sv
// Enemy ship: spawns at the top, descends to FOLLOW_Y, chases the player, takes laser damage, explodes, clears.
// Optional ENEMY_SPAWN_SHIELD_EN: laser hits ignored for the first 32 live frames after spawn.

module enemy_chaser_n_aabb (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] aw,
    input  logic [9:0] ah,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    input  logic [9:0] bw,
    input  logic [9:0] bh,
    output logic       hit
);
    assign hit = ({1'b0, ax} < {1'b0, bx} + {1'b0, bw}) &&
                 ({1'b0, bx} < {1'b0, ax} + {1'b0, aw}) &&
                 ({1'b0, ay} < {1'b0, by} + {1'b0, bh}) &&
                 ({1'b0, by} < {1'b0, ay} + {1'b0, ah});
endmodule

module enemy_chaser_n #(
    parameter int NUM_LASERS = 4,
    parameter int SHIP_W     = 30,
    parameter int SHIP_H     = 30,
    parameter int PLR_W      = 30,
    parameter int PLR_H      = 30,
    parameter int HP_INIT    = 4,
    parameter int EXPLODE_FR = 15,
    parameter int FOLLOW_Y   = 160,
    parameter int DEADBAND   = 5,
    parameter int SPEED_HARD = 2
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic                       spawn,
    input  logic [9:0]                 spawn_x,
    input  logic [2:0]                 difficulty,
    input  logic [9:0]                 laser_w,
    input  logic [9:0]                 laser_h,
    input  logic [10*NUM_LASERS-1:0]   laser_x,
    input  logic [10*NUM_LASERS-1:0]   laser_y,
    input  logic [NUM_LASERS-1:0]      laser_v,
    input  logic [9:0]                 player_x,
    input  logic [9:0]                 player_y,
    output logic [9:0]                 ship_x,
    output logic [9:0]                 ship_y,
    output logic                       ship_alive,
    output logic                       exploding,
    output logic [NUM_LASERS-1:0]      laser_hit,
    output logic                       player_hit,
    output logic [2:0]                 hp
);
    localparam logic [9:0] SW   = 10'(SHIP_W);
    localparam logic [9:0] SH   = 10'(SHIP_H);
    localparam logic [9:0] PW   = 10'(PLR_W);
    localparam logic [9:0] PH   = 10'(PLR_H);
    localparam logic [9:0] XM   = 10'(639 - SHIP_W);
    localparam logic [9:0] YM   = 10'(479 - SHIP_H);
    localparam logic [9:0] FY   = 10'(FOLLOW_Y);
    localparam logic [9:0] DB   = 10'(DEADBAND);
    localparam logic [9:0] SPH  = 10'(SPEED_HARD);
    localparam logic [2:0] HPI  = 3'(HP_INIT);
    localparam logic [3:0] EXF  = 4'(EXPLODE_FR);

    typedef enum logic [2:0] {IDLE, DESCEND, CHASE, EXPLODE, CLEAR} state_t;
    state_t state;

    logic [3:0]            timer;
    logic [NUM_LASERS-1:0] laser_ovl;
    logic [NUM_LASERS-1:0] hits;
    logic [NUM_LASERS-1:0] shield_mask;
    logic                  plr_ovl;
    logic [4:0]            hit_cnt;
    logic [4:0]            dmg;
    logic                  kill;
    logic [9:0]            step;
    logic [9:0]            nx, ny, y_desc, sx_clamp;
    logic                  unused_diff;

    assign unused_diff = difficulty[0];

    genvar g;
    generate
        for (g = 0; g < NUM_LASERS; g++) begin : g_las
            enemy_chaser_n_aabb u_ovl (
                .ax(ship_x), .ay(ship_y), .aw(SW), .ah(SH),
                .bx(laser_x[10*g +: 10]), .by(laser_y[10*g +: 10]),
                .bw(laser_w), .bh(laser_h),
                .hit(laser_ovl[g])
            );
        end
    endgenerate

    enemy_chaser_n_aabb u_plr (
        .ax(ship_x), .ay(ship_y), .aw(SW), .ah(SH),
        .bx(player_x), .by(player_y), .bw(PW), .bh(PH),
        .hit(plr_ovl)
    );

`ifdef ENEMY_SPAWN_SHIELD_EN
    logic [4:0] shield_cnt;
    logic       shield_on;
    assign shield_mask = shield_on ? '0 : '1;
`else
    assign shield_mask = '1;
`endif

    // Move one axis toward tgt by s, holding inside the dead-band and never leaving [0, maxv].
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic [9:0] tgt,
                                             input logic [9:0] s, input logic [9:0] maxv);
        logic [10:0] up;
        logic [9:0]  r;
        up = {1'b0, pos} + {1'b0, s};
        r  = pos;
        if (pos > tgt) begin
            if (pos - tgt >= DB) r = (pos < s) ? 10'd0 : pos - s;
        end else if (tgt - pos >= DB) begin
            r = (up > {1'b0, maxv}) ? maxv : up[9:0];
        end
        if (r > maxv) r = maxv;
        return r;
    endfunction

    always_comb begin
        hits    = laser_v & laser_ovl & shield_mask;
        hit_cnt = '0;
        for (int i = 0; i < NUM_LASERS; i++) hit_cnt = hit_cnt + 5'(hits[i]);
        dmg      = difficulty[1] ? {hit_cnt[3:0], 1'b0} : hit_cnt;
        kill     = dmg >= {2'b00, hp};
        step     = difficulty[2] ? SPH : 10'd1;
        nx       = step_axis(ship_x, player_x, step, XM);
        ny       = step_axis(ship_y, player_y, step, YM);
        y_desc   = (ship_y >= YM) ? YM : ship_y + 10'd1;
        sx_clamp = (spawn_x > XM) ? XM : spawn_x;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            ship_x     <= 10'd639;
            ship_y     <= 10'd0;
            hp         <= 3'd0;
            timer      <= 4'd0;
            ship_alive <= 1'b0;
            exploding  <= 1'b0;
            laser_hit  <= '0;
            player_hit <= 1'b0;
`ifdef ENEMY_SPAWN_SHIELD_EN
            shield_cnt <= 5'd0;
            shield_on  <= 1'b0;
`endif
        end else begin
            laser_hit  <= '0;
            player_hit <= 1'b0;
            case (state)
                IDLE: if (spawn) begin
                    state      <= DESCEND;
                    ship_x     <= sx_clamp;
                    ship_y     <= 10'd2;
                    hp         <= HPI;
                    timer      <= EXF;
                    ship_alive <= 1'b1;
`ifdef ENEMY_SPAWN_SHIELD_EN
                    shield_cnt <= 5'd0;
                    shield_on  <= 1'b1;
`endif
                end
                DESCEND, CHASE: begin
                    laser_hit <= hits;
                    hp        <= kill ? 3'd0 : hp - dmg[2:0];
`ifdef ENEMY_SPAWN_SHIELD_EN
                    if (shield_on) begin
                        shield_cnt <= shield_cnt + 5'd1;
                        if (shield_cnt == 5'd31) shield_on <= 1'b0;
                    end
`endif
                    // A ram or a lethal hit freezes the ship where it was struck.
                    if (plr_ovl || kill) begin
                        state      <= EXPLODE;
                        exploding  <= 1'b1;
                        player_hit <= plr_ovl;
                    end else if (state == DESCEND) begin
                        ship_y <= y_desc;
                        if (y_desc > FY) state <= CHASE;
                    end else begin
                        ship_x <= nx;
                        ship_y <= ny;
                    end
                end
                EXPLODE: begin
                    if (timer == 4'd0) begin
                        state      <= CLEAR;
                        ship_x     <= 10'd639;
                        ship_y     <= 10'd0;
                        hp         <= 3'd0;
                        ship_alive <= 1'b0;
                        exploding  <= 1'b0;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                CLEAR: begin
                    state  <= IDLE;
                    ship_x <= 10'd639;
                    ship_y <= 10'd0;
                    hp     <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enemy_chaser_n.sv
// Directed bench for enemy_chaser_n: reset, descent, chase table, laser damage, explosion, ram.
`timescale 1ns/1ps
module tb_enemy_chaser_n;
    localparam int NL = 4;

    logic            frame_clk = 1'b0;
    logic            Reset = 1'b0;
    logic            spawn = 1'b0;
    logic [9:0]      spawn_x = '0;
    logic [2:0]      difficulty = 3'b010;
    logic [9:0]      laser_w = 10'd4;
    logic [9:0]      laser_h = 10'd10;
    logic [10*NL-1:0] laser_x = '0;
    logic [10*NL-1:0] laser_y = '0;
    logic [NL-1:0]   laser_v = '0;
    logic [9:0]      player_x = 10'd400;
    logic [9:0]      player_y = 10'd400;
    logic [9:0]      ship_x, ship_y;
    logic            ship_alive, exploding, player_hit;
    logic [NL-1:0]   laser_hit;
    logic [2:0]      hp;

    int checks = 0;
    int errors = 0;

    enemy_chaser_n #(.NUM_LASERS(NL)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .spawn(spawn), .spawn_x(spawn_x),
        .difficulty(difficulty), .laser_w(laser_w), .laser_h(laser_h),
        .laser_x(laser_x), .laser_y(laser_y), .laser_v(laser_v),
        .player_x(player_x), .player_y(player_y),
        .ship_x(ship_x), .ship_y(ship_y), .ship_alive(ship_alive), .exploding(exploding),
        .laser_hit(laser_hit), .player_hit(player_hit), .hp(hp)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [2:0] diff;
        logic [9:0] px, py;
        logic [3:0] lv;
        logic [9:0] ex, ey;
        logic [2:0] ehp;
        logic [3:0] elh;
        logic       eph, eex;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_laser(input int i, input logic [9:0] x, input logic [9:0] y);
        laser_x[10*i +: 10] = x;
        laser_y[10*i +: 10] = y;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        difficulty = v.diff;
        player_x   = v.px;
        player_y   = v.py;
        laser_v    = v.lv;
        tick();
        chk({tag, ".x"}, 32'(ship_x), 32'(v.ex));
        chk({tag, ".y"}, 32'(ship_y), 32'(v.ey));
        chk({tag, ".hp"}, 32'(hp), 32'(v.ehp));
        chk({tag, ".laser_hit"}, 32'(laser_hit), 32'(v.elh));
        chk({tag, ".player_hit"}, 32'(player_hit), 32'(v.eph));
        chk({tag, ".exploding"}, 32'(exploding), 32'(v.eex));
    endtask

    task automatic do_spawn(input logic [9:0] x);
        spawn   = 1'b1;
        spawn_x = x;
        tick();
        spawn   = 1'b0;
    endtask

    vec_t chase_tab[9];
    vec_t easy_tab[5];

    initial begin
        chase_tab[0] = '{3'b010, 10'd400, 10'd400, 4'd0, 10'd149, 10'd162, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[1] = '{3'b100, 10'd400, 10'd400, 4'd0, 10'd151, 10'd164, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[2] = '{3'b100, 10'd153, 10'd400, 4'd0, 10'd151, 10'd166, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[3] = '{3'b100, 10'd300, 10'd300, 4'd0, 10'd153, 10'd168, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[4] = '{3'b001, 10'd300, 10'd300, 4'd0, 10'd154, 10'd169, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[5] = '{3'b100, 10'd149, 10'd400, 4'd0, 10'd152, 10'd171, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[6] = '{3'b100, 10'd149, 10'd400, 4'd0, 10'd152, 10'd173, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[7] = '{3'b100, 10'd100, 10'd177, 4'd0, 10'd150, 10'd173, 3'd4, 4'd0, 1'b0, 1'b0};
        chase_tab[8] = '{3'b100, 10'd100, 10'd100, 4'd0, 10'd148, 10'd171, 3'd4, 4'd0, 1'b0, 1'b0};

        easy_tab[0] = '{3'b001, 10'd500, 10'd0, 4'b1010, 10'd148, 10'd3, 3'd3, 4'b0010, 1'b0, 1'b0};
        easy_tab[1] = '{3'b001, 10'd500, 10'd0, 4'b1010, 10'd148, 10'd4, 3'd2, 4'b0010, 1'b0, 1'b0};
        easy_tab[2] = '{3'b001, 10'd500, 10'd0, 4'b1010, 10'd148, 10'd5, 3'd1, 4'b0010, 1'b0, 1'b0};
        easy_tab[3] = '{3'b001, 10'd500, 10'd0, 4'b1010, 10'd148, 10'd5, 3'd0, 4'b0010, 1'b0, 1'b1};
        easy_tab[4] = '{3'b001, 10'd500, 10'd0, 4'b0000, 10'd148, 10'd5, 3'd0, 4'b0000, 1'b0, 1'b1};

        // Reset state
        #2 Reset = 1'b1;
        #1;
        chk("rst.x", 32'(ship_x), 32'd639);
        chk("rst.y", 32'(ship_y), 32'd0);
        chk("rst.hp", 32'(hp), 32'd0);
        chk("rst.alive", 32'(ship_alive), 32'd0);
        chk("rst.exploding", 32'(exploding), 32'd0);
        chk("rst.laser_hit", 32'(laser_hit), 32'd0);
        chk("rst.player_hit", 32'(player_hit), 32'd0);
        repeat (2) @(posedge frame_clk);
        @(negedge frame_clk) Reset = 1'b0;

        // Descent, normal difficulty, lasers off
        difficulty = 3'b010;
        player_x = 10'd400;
        player_y = 10'd400;
        do_spawn(10'd148);
        chk("spawn.x", 32'(ship_x), 32'd148);
        chk("spawn.y", 32'(ship_y), 32'd2);
        chk("spawn.hp", 32'(hp), 32'd4);
        chk("spawn.alive", 32'(ship_alive), 32'd1);
        for (int k = 1; k <= 159; k++) begin
            tick();
            chk("descend.y", 32'(ship_y), 32'(2 + k));
        end
        chk("descend.x", 32'(ship_x), 32'd148);
        chk("descend.hp", 32'(hp), 32'd4);

        // Chase table: the first row moves x only if CHASE began on the y=161 frame
        for (int i = 0; i < 9; i++) run_vec($sformatf("chase[%0d]", i), chase_tab[i]);

        // Clamp at the far corner, no wrap
        difficulty = 3'b100;
        player_x = 10'd1000;
        player_y = 10'd1000;
        repeat (240) tick();
        chk("clamp.x", 32'(ship_x), 32'd609);
        chk("clamp.y", 32'(ship_y), 32'd449);

        // Asynchronous reset mid-CHASE
        #2 Reset = 1'b1;
        #1;
        chk("midrst.x", 32'(ship_x), 32'd639);
        chk("midrst.y", 32'(ship_y), 32'd0);
        chk("midrst.hp", 32'(hp), 32'd0);
        chk("midrst.alive", 32'(ship_alive), 32'd0);
        chk("midrst.laser_hit", 32'(laser_hit), 32'd0);
        @(negedge frame_clk) Reset = 1'b0;

`ifdef ENEMY_SPAWN_SHIELD_EN
        difficulty = 3'b001;
        player_x = 10'd500;
        player_y = 10'd0;
        do_spawn(10'd148);
        for (int f = 1; f <= 40; f++) begin
            laser_v = '0;
            if (f == 10 || f == 40) begin
                set_laser(0, 10'd150, 10'(2 + f - 1));
                laser_v = 4'b0001;
            end
            tick();
            if (f == 10) begin
                chk("shield.f10.laser_hit", 32'(laser_hit), 32'd0);
                chk("shield.f10.hp", 32'(hp), 32'd4);
            end
            if (f == 40) begin
                chk("shield.f40.laser_hit", 32'(laser_hit), 32'd1);
                chk("shield.f40.hp", 32'(hp), 32'd3);
            end
        end
        laser_v = '0;
        difficulty = 3'b010;
        repeat (60) tick();
`else
        // Two lasers on one frame, normal: 2 hits x2 = lethal
        difficulty = 3'b010;
        player_x = 10'd500;
        player_y = 10'd0;
        do_spawn(10'd148);
        set_laser(0, 10'd150, 10'd10);
        set_laser(1, 10'd0,   10'd400);
        set_laser(2, 10'd160, 10'd20);
        set_laser(3, 10'd600, 10'd400);
        laser_v = 4'b1111;
        tick();
        chk("dbl.laser_hit", 32'(laser_hit), 32'b0101);
        chk("dbl.hp", 32'(hp), 32'd0);
        chk("dbl.exploding", 32'(exploding), 32'd1);
        chk("dbl.y_frozen", 32'(ship_y), 32'd2);
        laser_v = '0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) chk("dbl.pulse_off", 32'(laser_hit), 32'd0);
            if (k == 15) chk("dbl.alive_f15", 32'(ship_alive), 32'd1);
        end
        tick();
        chk("dbl.alive_f16", 32'(ship_alive), 32'd0);
        chk("dbl.exploding_f16", 32'(exploding), 32'd0);
        tick();
        chk("dbl.clear.x", 32'(ship_x), 32'd639);
        chk("dbl.clear.y", 32'(ship_y), 32'd0);

        // One laser repeatedly, easy; laser 3 only touches the right edge
        difficulty = 3'b001;
        do_spawn(10'd148);
        set_laser(1, 10'd150, 10'd20);
        set_laser(3, 10'd178, 10'd10);
        for (int i = 0; i < 5; i++) run_vec($sformatf("easy[%0d]", i), easy_tab[i]);
        repeat (18) tick();
        chk("easy.idle.alive", 32'(ship_alive), 32'd0);
`endif

        // Ram: player overlap explodes at once; spawn ignored while busy
        difficulty = 3'b010;
        laser_v = '0;
        player_x = 10'd150;
        player_y = 10'd10;
        do_spawn(10'd148);
        chk("ram.spawn.y", 32'(ship_y), 32'd2);
        tick();
        chk("ram.player_hit", 32'(player_hit), 32'd1);
        chk("ram.exploding", 32'(exploding), 32'd1);
        chk("ram.y_frozen", 32'(ship_y), 32'd2);
        chk("ram.hp", 32'(hp), 32'd4);
        do_spawn(10'd300);
        chk("ram.pulse_off", 32'(player_hit), 32'd0);
        chk("ram.spawn_ignored.x", 32'(ship_x), 32'd148);
        chk("ram.still_exploding", 32'(exploding), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
